// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants, counter type and sync window helper.
// Imported by the sync generator and by the graphics stage (MAX_X/MAX_Y).
package vga_timing_pkg;

  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // Graphics-side bounds: first coordinate outside the visible area.
  localparam int MAX_X = VGA_H_DISPLAY;
  localparam int MAX_Y = VGA_V_DISPLAY;

  localparam int   CNT_W       = 10;
  localparam logic SYNC_ACTIVE = 1'b0;

  typedef logic [CNT_W-1:0] cnt_t;

  // True when count c lies in [lo, lo+len).
  function automatic logic in_window(cnt_t c, int lo, int len);
    return (int'(c) >= lo) && (int'(c) < (lo + len));
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Mod-CLK_DIV free-running counter; p_tick is high for one clk every CLK_DIV clks.
module pixel_tick_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if ((CLK_DIV < 1) || (CLK_DIV > 16)) begin : g_bad_div
    $error("pixel_tick_div: CLK_DIV must be in 1..16");
  end

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (div_cnt_q >= DIV_LAST) begin
      div_cnt_d = '0;
    end
  end

  // With CLK_DIV=1 the counter is stuck at 0, so the tick is permanently high.
  assign p_tick = (div_cnt_q == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Free-running VGA timing generator: pixel-rate tick, h/v position counters, sync pins.
// Optional VGA_SYNC_FRAME_TICK_EN adds frame_tick, a one-clk strobe at the start of vblank.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = VGA_H_DISPLAY,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_DISPLAY = VGA_V_DISPLAY,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK,
  parameter int CLK_DIV   = 2
) (
  input  logic             clk,
  input  logic             reset,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             p_tick,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y
`ifdef VGA_SYNC_FRAME_TICK_EN
  ,
  output logic             frame_tick
`endif
);

  localparam int LINE_LEN  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int FRAME_LEN = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START  = H_DISPLAY + H_FRONT;
  localparam int VS_START  = V_DISPLAY + V_FRONT;

  localparam cnt_t H_LAST = cnt_t'(LINE_LEN - 1);
  localparam cnt_t V_LAST = cnt_t'(FRAME_LEN - 1);
  localparam cnt_t H_VIS  = cnt_t'(H_DISPLAY);
  localparam cnt_t V_VIS  = cnt_t'(V_DISPLAY);

  if ((LINE_LEN > (1 << CNT_W)) || (FRAME_LEN > (1 << CNT_W))) begin : g_bad_totals
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must both be <= 1024");
  end

  pixel_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_div (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  cnt_t h_count_q;
  cnt_t h_count_d;
  cnt_t v_count_q;
  cnt_t v_count_d;
  logic hsync_q;
  logic hsync_d;
  logic vsync_q;
  logic vsync_d;
  logic line_end;

  always_comb begin
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    line_end  = 1'b0;
    if (p_tick) begin
      if (h_count_q >= H_LAST) begin
        h_count_d = '0;
        line_end  = 1'b1;
      end else begin
        h_count_d = h_count_q + 1'b1;
      end
    end
    if (line_end) begin
      if (v_count_q >= V_LAST) begin
        v_count_d = '0;
      end else begin
        v_count_d = v_count_q + 1'b1;
      end
    end
    // Syncs decode the next counts so they change on the same edge as the counters.
    hsync_d = in_window(h_count_d, HS_START, H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d = in_window(v_count_d, VS_START, V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_count_q <= '0;
      v_count_q <= '0;
      hsync_q   <= ~SYNC_ACTIVE;
      vsync_q   <= ~SYNC_ACTIVE;
    end else begin
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
    end
  end

  assign pixel_x  = h_count_q;
  assign pixel_y  = v_count_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign video_on = (h_count_q < H_VIS) && (v_count_q < V_VIS);

`ifdef VGA_SYNC_FRAME_TICK_EN
  logic frame_tick_q;
  logic frame_tick_d;

  // Counts enter (0, V_DISPLAY) only on a line-end edge.
  always_comb begin
    frame_tick_d = line_end && (v_count_d == V_VIS);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= frame_tick_d;
    end
  end

  assign frame_tick = frame_tick_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 640x480 timing (CLK_DIV=2) plus two reduced-timing
// instances (15x10 totals, CLK_DIV=2 and CLK_DIV=1) so full frames stay short.
module tb_vga_sync_gen;

  localparam int W = 23;  // {x[9:0], y[9:0], hsync, vsync, video_on}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  logic [9:0] x0, y0, x1, y1, x2, y2;
  logic hs0, vs0, von0, pt0, hs1, vs1, von1, pt1, hs2, vs2, von2, pt2;
`ifdef VGA_SYNC_FRAME_TICK_EN
  logic ft0, ft1, ft2;
`endif

  vga_sync_gen #(.CLK_DIV(2)) u0 (
    .clk(clk), .reset(reset), .hsync(hs0), .vsync(vs0), .video_on(von0),
    .p_tick(pt0), .pixel_x(x0), .pixel_y(y0)
`ifdef VGA_SYNC_FRAME_TICK_EN
    , .frame_tick(ft0)
`endif
  );

  vga_sync_gen #(.H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                 .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .CLK_DIV(2)) u1 (
    .clk(clk), .reset(reset), .hsync(hs1), .vsync(vs1), .video_on(von1),
    .p_tick(pt1), .pixel_x(x1), .pixel_y(y1)
`ifdef VGA_SYNC_FRAME_TICK_EN
    , .frame_tick(ft1)
`endif
  );

  vga_sync_gen #(.H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                 .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .CLK_DIV(1)) u2 (
    .clk(clk), .reset(reset), .hsync(hs2), .vsync(vs2), .video_on(von2),
    .p_tick(pt2), .pixel_x(x2), .pixel_y(y2)
`ifdef VGA_SYNC_FRAME_TICK_EN
    , .frame_tick(ft2)
`endif
  );

  // Observation mux: tests select which instance they are watching.
  int sel = 0;
  logic [W-1:0] obs_state;
  logic obs_pt;
  logic obs_ft;
  always_comb begin
    obs_state = {x0, y0, hs0, vs0, von0};
    obs_pt    = pt0;
    obs_ft    = 1'b0;
    case (sel)
      1: begin obs_state = {x1, y1, hs1, vs1, von1}; obs_pt = pt1; end
      2: begin obs_state = {x2, y2, hs2, vs2, von2}; obs_pt = pt2; end
      default: ;
    endcase
`ifdef VGA_SYNC_FRAME_TICK_EN
    case (sel)
      1: obs_ft = ft1;
      2: obs_ft = ft2;
      default: obs_ft = ft0;
    endcase
`endif
  end

  // ---------------- reference timing ----------------
  function automatic logic [W-1:0] exp_state(int k, int hd, int hf, int hsw, int hb,
                                             int vd, int vf, int vsw, int vb);
    int ht, vt, x, y;
    logic hsn, vsn, von;
    ht  = hd + hf + hsw + hb;
    vt  = vd + vf + vsw + vb;
    x   = k % ht;
    y   = (k / ht) % vt;
    hsn = !((x >= hd + hf) && (x < hd + hf + hsw));
    vsn = !((y >= vd + vf) && (y < vd + vf + vsw));
    von = (x < hd) && (y < vd);
    return {10'(x), 10'(y), hsn, vsn, von};
  endfunction

  function automatic logic [W-1:0] exp_def(int k);
    return exp_state(k, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic logic [W-1:0] exp_small(int k);
    return exp_state(k, 8, 2, 3, 2, 6, 1, 2, 1);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Advance to the next pixel edge; reports clks taken, early movement, stray frame_tick.
  task automatic step_pixel(output logic [W-1:0] st, output int clks, output bit moved,
                            output int ft_extra, output logic ft_at);
    logic [W-1:0] start;
    start = obs_state;
    clks = 0;
    moved = 1'b0;
    ft_extra = 0;
    while ((obs_pt !== 1'b1) && (clks < 40)) begin
      @(negedge clk);
      clks++;
      if (obs_state !== start) moved = 1'b1;
      if (obs_ft === 1'b1) ft_extra++;
    end
    @(negedge clk);
    clks++;
    st = obs_state;
    ft_at = obs_ft;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++;
      if (obs_state !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL reset_state dut=%0d got=%h exp=%h", s, obs_state, {10'd0, 10'd0, 3'b111});
      end
      checks++;
      if (obs_pt !== (s == 2)) begin
        errors++;
        $display("FAIL reset_p_tick dut=%0d got=%b exp=%b", s, obs_pt, (s == 2));
      end
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_line();
    logic [W-1:0] st, e;
    int clks, fte;
    bit moved;
    logic fta;
    sel = 0;
    apply_reset();
    for (int k = 1; k <= 801; k++) exp_q.push_back(exp_def(k));
    for (int k = 1; k <= 801; k++) begin
      step_pixel(st, clks, moved, fte, fta);
      e = exp_q.pop_front();
      checks++;
      if (st !== e) begin
        errors++;
        $display("FAIL line_state k=%0d got=%h exp=%h", k, st, e);
      end
      checks++;
      if (clks != 2 || moved) begin
        errors++;
        $display("FAIL line_tick_period k=%0d clks=%0d moved=%0b exp clks=2 moved=0", k, clks, moved);
      end
    end
  endtask

  task automatic test_frame();
    logic [W-1:0] st, e;
    int clks, fte, total, von_cnt;
    bit moved;
    logic fta;
    sel = 1;
    apply_reset();
    for (int k = 1; k <= 301; k++) exp_q.push_back(exp_small(k));
    total = 0;
    von_cnt = int'(obs_state[0]);
    for (int k = 1; k <= 301; k++) begin
      step_pixel(st, clks, moved, fte, fta);
      total += clks;
      e = exp_q.pop_front();
      checks++;
      if (st !== e || clks != 2 || moved) begin
        errors++;
        $display("FAIL frame_state k=%0d got=%h exp=%h clks=%0d moved=%0b", k, st, e, clks, moved);
      end
      if (k < 150) von_cnt += int'(st[0]);
      if (k == 150) begin
        checks++;
        if (total != 300 || st[22:3] !== 20'd0) begin
          errors++;
          $display("FAIL frame_period clks=%0d xy=%h exp clks=300 xy=0", total, st[22:3]);
        end
        checks++;
        if (von_cnt != 48) begin
          errors++;
          $display("FAIL frame_video_on_count got=%0d exp=48", von_cnt);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] st, e;
    int clks, fte;
    bit moved;
    logic fta;
    sel = 1;
    apply_reset();
    for (int k = 1; k <= 49; k++) step_pixel(st, clks, moved, fte, fta);
    checks++;
    if (st !== exp_small(49)) begin
      errors++;
      $display("FAIL midreset_pre got=%h exp=%h", st, exp_small(49));
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs_state !== {10'd0, 10'd0, 3'b111} || obs_pt !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async got=%h pt=%b exp=%h pt=0", obs_state, obs_pt, {20'd0, 3'b111});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (obs_state !== {10'd0, 10'd0, 3'b111} || obs_pt !== 1'b0) begin
        errors++;
        $display("FAIL midreset_hold c=%0d got=%h pt=%b exp=%h pt=0", c, obs_state, obs_pt, {20'd0, 3'b111});
      end
    end
    reset = 1'b0;
    for (int k = 1; k <= 150; k++) exp_q.push_back(exp_small(k));
    for (int k = 1; k <= 150; k++) begin
      step_pixel(st, clks, moved, fte, fta);
      e = exp_q.pop_front();
      checks++;
      if (st !== e || clks != 2 || moved) begin
        errors++;
        $display("FAIL midreset_restart k=%0d got=%h exp=%h clks=%0d moved=%0b", k, st, e, clks, moved);
      end
    end
  endtask

  task automatic test_div1();
    logic [W-1:0] st, e;
    int clks, fte, total;
    bit moved;
    logic fta;
    sel = 2;
    apply_reset();
    checks++;
    if (obs_pt !== 1'b1) begin
      errors++;
      $display("FAIL div1_p_tick got=%b exp=1", obs_pt);
    end
    for (int k = 1; k <= 301; k++) exp_q.push_back(exp_small(k));
    total = 0;
    for (int k = 1; k <= 301; k++) begin
      step_pixel(st, clks, moved, fte, fta);
      total += clks;
      e = exp_q.pop_front();
      checks++;
      if (st !== e || clks != 1 || obs_pt !== 1'b1) begin
        errors++;
        $display("FAIL div1_state k=%0d got=%h exp=%h clks=%0d pt=%b", k, st, e, clks, obs_pt);
      end
      if (k == 15 || k == 150) begin
        checks++;
        if (total != k) begin
          errors++;
          $display("FAIL div1_period k=%0d clks=%0d exp=%0d", k, total, k);
        end
      end
    end
  endtask

`ifdef VGA_SYNC_FRAME_TICK_EN
  task automatic test_frame_tick();
    logic [W-1:0] st;
    int clks, fte, pulses;
    bit moved;
    logic fta;
    logic [W-1:0] exp_ft_q[$];
    sel = 1;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (obs_ft !== 1'b0) begin
        errors++;
        $display("FAIL ftick_in_reset c=%0d got=%b exp=0", c, obs_ft);
      end
    end
    reset = 1'b0;
    for (int k = 1; k <= 300; k++) exp_ft_q.push_back(W'((k % 150) == 90));
    pulses = 0;
    for (int k = 1; k <= 300; k++) begin
      step_pixel(st, clks, moved, fte, fta);
      pulses += fte + int'(fta);
      checks++;
      if (fta !== exp_ft_q.pop_front() || fte != 0) begin
        errors++;
        $display("FAIL ftick k=%0d xy=%h got=%b extra=%0d exp=%b", k, st[22:3], fta, fte, (k % 150) == 90);
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL ftick_count got=%0d exp=2", pulses);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_mid_reset();
    test_div1();
`ifdef VGA_SYNC_FRAME_TICK_EN
    test_frame_tick();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
